// File: rtl/ir_rf_pkg.sv
// Shared encodings for the IR / register-file slice: write-back source codes
// and instruction-word field positions.
package ir_rf_pkg;

  typedef enum logic [2:0] {
    RWS_ALUO  = 3'b000,
    RWS_MD    = 3'b001,
    RWS_PC    = 3'b010,
    RWS_B     = 3'b011,
    RWS_UPPER = 3'b100,
    RWS_SIGNE = 3'b101,
    RWS_IMM8  = 3'b110,
    RWS_NONE  = 3'b111
  } rwsrc_e;

  localparam int OP_HI   = 15;
  localparam int OP_LO   = 12;
  localparam int RA_LO   = 8;
  localparam int RB_LO   = 4;
  localparam int IMM_HI  = 11;
  localparam int IMM_LO  = 4;
  localparam int LMC_BIT = 3;
  localparam int CC_HI   = 2;
  localparam int CC_LO   = 0;
  localparam int IMM8_W  = 8;

endpackage

// File: rtl/ir_regfile_pipe_rf_array.sv
// NREG x WIDTH register storage, one write port, two registered read ports.
// Read latency 1 cycle; optional same-edge write forwarding; no backpressure.
module rf_array #(
  parameter int WIDTH   = 16,
  parameter int NREG    = 16,
  parameter int AW      = 4,
  parameter bit BYPASS  = 1'b1,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_we,
  input  logic [AW-1:0]    i_wa,
  input  logic [WIDTH-1:0] i_wd,
  input  logic [AW-1:0]    i_ra1,
  input  logic [AW-1:0]    i_ra2,
  output logic [WIDTH-1:0] o_rd1,
  output logic [WIDTH-1:0] o_rd2
);

  logic [WIDTH-1:0] r_mem [NREG];
  logic [WIDTH-1:0] w_rd1;
  logic [WIDTH-1:0] w_rd2;

  always_comb begin
    w_rd1 = r_mem[i_ra1];
    w_rd2 = r_mem[i_ra2];
    if (BYPASS && i_we && (i_wa == i_ra1)) w_rd1 = i_wd;
    if (BYPASS && i_we && (i_wa == i_ra2)) w_rd2 = i_wd;
    // r0 is also never written, but gate the read so it cannot leak state
    if (ZERO_R0 && (i_ra1 == '0)) w_rd1 = '0;
    if (ZERO_R0 && (i_ra2 == '0)) w_rd2 = '0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
      o_rd1 <= '0;
      o_rd2 <= '0;
    end else begin
      if (i_we) r_mem[i_wa] <= i_wd;
      o_rd1 <= w_rd1;
      o_rd2 <= w_rd2;
    end
  end

endmodule

// File: rtl/ir_regfile_pipe.sv
// IR latch + decode, write-back mux, register file and busy scoreboard.
// Decode/Hazard combinational from state; D1/D2 one-cycle latency; no backpressure.
module ir_regfile_pipe
  import ir_rf_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int NREG     = 16,
  parameter int LINK_REG = NREG - 1,
  parameter bit ZERO_R0  = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IW,
  input  logic [15:0]      MD,
  input  logic             RW,
  input  logic             WLink,
  input  logic [2:0]       RWSrc,
  input  logic [WIDTH-1:0] ALUO,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] PC,
  input  logic             Mark,
  output logic [3:0]       Op,
  output logic             LMC,
  output logic [2:0]       CC,
  output logic [WIDTH-1:0] upper,
  output logic [WIDTH-1:0] signE,
  output logic [WIDTH-1:0] D1,
  output logic [WIDTH-1:0] D2,
  output logic             Hazard,
  output logic [NREG-1:0]  BusyVec
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [AW-1:0] LINK_A = AW'(LINK_REG);

  logic [15:0]       r_ir;
  logic [NREG-1:0]   r_busy;
  logic [NREG-1:0]   w_busy_nxt;
  logic [IMM8_W-1:0] w_imm8;
  logic [AW-1:0]     w_ra;
  logic [AW-1:0]     w_rb;
  logic [AW-1:0]     w_wa;
  logic [WIDTH-1:0]  w_md_ext;
  logic [WIDTH-1:0]  w_imm_ext;
  logic [WIDTH-1:0]  w_wd;
  logic              w_we;

  assign w_imm8 = r_ir[IMM_HI:IMM_LO];
  assign w_ra   = r_ir[RA_LO +: AW];
  assign w_rb   = r_ir[RB_LO +: AW];
  assign w_wa   = WLink ? LINK_A : w_ra;

  assign Op    = r_ir[OP_HI:OP_LO];
  assign LMC   = r_ir[LMC_BIT];
  assign CC    = r_ir[CC_HI:CC_LO];
  assign signE = {{(WIDTH-IMM8_W){w_imm8[IMM8_W-1]}}, w_imm8};

  always_comb begin
    upper           = '0;
    upper[15:8]     = w_imm8;
    w_md_ext        = '0;
    w_md_ext[15:0]  = MD;
    w_imm_ext       = '0;
    w_imm_ext[IMM8_W-1:0] = w_imm8;
  end

  // Sources that depend on the IR see the pre-edge IR, even if IW is also high
  always_comb begin
    w_wd = '0;
    case (RWSrc)
      RWS_ALUO:  w_wd = ALUO;
      RWS_MD:    w_wd = w_md_ext;
      RWS_PC:    w_wd = PC;
      RWS_B:     w_wd = B;
      RWS_UPPER: w_wd = upper;
      RWS_SIGNE: w_wd = signE;
      RWS_IMM8:  w_wd = w_imm_ext;
      default:   w_wd = '0;
    endcase
  end

  assign w_we = RW && (RWSrc != RWS_NONE) && !(ZERO_R0 && (w_wa == '0));

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_we) w_busy_nxt[w_wa] = 1'b0;
    if (Mark) w_busy_nxt[w_ra] = 1'b1;
    if (ZERO_R0) w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_ir   <= '0;
      r_busy <= '0;
    end else begin
      if (IW) r_ir <= MD;
      r_busy <= w_busy_nxt;
    end
  end

  assign Hazard  = r_busy[w_ra] | r_busy[w_rb];
  assign BusyVec = r_busy;

  rf_array #(
    .WIDTH   (WIDTH),
    .NREG    (NREG),
    .AW      (AW),
    .BYPASS  (BYPASS),
    .ZERO_R0 (ZERO_R0)
  ) u_rf (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_we    (w_we),
    .i_wa    (w_wa),
    .i_wd    (w_wd),
    .i_ra1   (w_ra),
    .i_ra2   (w_rb),
    .o_rd1   (D1),
    .o_rd2   (D2)
  );

endmodule

// File: tb/tb_ir_regfile_pipe.sv
// Scoreboard bench for ir_regfile_pipe: directed plan steps, then random traffic
// against an array-based reference model.
module tb_ir_regfile_pipe;

  localparam int W = 16;
  localparam int N = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, iw, rw, wlink, mark;
  logic [15:0]   md;
  logic [2:0]    rwsrc;
  logic [W-1:0]  aluo, b_op, pc;
  logic [3:0]    op;
  logic          lmc, hazard;
  logic [2:0]    cc;
  logic [W-1:0]  upper, signe, d1, d2;
  logic [N-1:0]  busyvec;

  ir_regfile_pipe #(.WIDTH(W), .NREG(N), .LINK_REG(N-1), .ZERO_R0(1'b1), .BYPASS(1'b1)) dut (
    .CLK(clk), .RST_N(rst_n), .IW(iw), .MD(md), .RW(rw), .WLink(wlink), .RWSrc(rwsrc),
    .ALUO(aluo), .B(b_op), .PC(pc), .Mark(mark), .Op(op), .LMC(lmc), .CC(cc),
    .upper(upper), .signE(signe), .D1(d1), .D2(d2), .Hazard(hazard), .BusyVec(busyvec)
  );

  typedef struct {
    logic [3:0]  op;
    logic        lmc;
    logic [2:0]  cc;
    logic [15:0] upper, signe, d1, d2;
    logic        hazard;
    logic [15:0] busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Reference model: architectural state only
  logic [15:0] m_ir;
  logic [15:0] m_rf [N];
  bit          m_busy [N];
  logic [15:0] m_d1, m_d2;

  task automatic step(input bit r, input bit iw_i, input logic [15:0] md_i, input bit rw_i,
                      input bit wl_i, input logic [2:0] src_i, input logic [15:0] alu_i,
                      input logic [15:0] b_i, input logic [15:0] pc_i, input bit mark_i);
    int ra, rb, wa;
    logic [7:0] imm;
    logic [15:0] wv;
    bit commit;
    exp_t e;
    rst_n = r; iw = iw_i; md = md_i; rw = rw_i; wlink = wl_i; rwsrc = src_i;
    aluo = alu_i; b_op = b_i; pc = pc_i; mark = mark_i;
    if (!r) begin
      m_ir = 0; m_d1 = 0; m_d2 = 0;
      for (int i = 0; i < N; i++) begin m_rf[i] = 0; m_busy[i] = 0; end
    end else begin
      ra = int'(m_ir[11:8]);
      rb = int'(m_ir[7:4]);
      imm = m_ir[11:4];
      case (src_i)
        3'd0: wv = alu_i;
        3'd1: wv = md_i;
        3'd2: wv = pc_i;
        3'd3: wv = b_i;
        3'd4: wv = {imm, 8'h00};
        3'd5: wv = {{8{imm[7]}}, imm};
        3'd6: wv = {8'h00, imm};
        default: wv = 16'h0;
      endcase
      wa = wl_i ? N - 1 : ra;
      commit = rw_i && (src_i != 3'd7) && (wa != 0);
      m_d1 = (commit && wa == ra) ? wv : m_rf[ra];
      m_d2 = (commit && wa == rb) ? wv : m_rf[rb];
      if (ra == 0) m_d1 = 0;
      if (rb == 0) m_d2 = 0;
      if (commit) begin m_rf[wa] = wv; m_busy[wa] = 0; end
      if (mark_i) m_busy[ra] = 1;
      m_busy[0] = 0;
      if (iw_i) m_ir = md_i;
    end
    e.op = m_ir[15:12]; e.lmc = m_ir[3]; e.cc = m_ir[2:0];
    e.upper = {m_ir[11:4], 8'h00};
    e.signe = {{8{m_ir[11]}}, m_ir[11:4]};
    e.d1 = m_d1; e.d2 = m_d2;
    e.hazard = m_busy[m_ir[11:8]] | m_busy[m_ir[7:4]];
    for (int i = 0; i < N; i++) e.busy[i] = m_busy[i];
    @(posedge clk); #1;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    step(1, 0, 16'h0, 0, 0, 3'd7, 16'h0, 16'h0, 16'h0, 0);
  endtask

  task automatic settle();
    #5;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("Op", 32'(op), 32'(e.op));
        chk("LMC", 32'(lmc), 32'(e.lmc));
        chk("CC", 32'(cc), 32'(e.cc));
        chk("upper", 32'(upper), 32'(e.upper));
        chk("signE", 32'(signe), 32'(e.signe));
        chk("D1", 32'(d1), 32'(e.d1));
        chk("D2", 32'(d2), 32'(e.d2));
        chk("Hazard", 32'(hazard), 32'(e.hazard));
        chk("BusyVec", 32'(busyvec), 32'(e.busy));
      end
    end
  end

  initial begin
    int k;
    rst_n = 0; iw = 0; md = 0; rw = 0; wlink = 0; rwsrc = 3'd7;
    aluo = 0; b_op = 0; pc = 0; mark = 0;

    step(0, 0, 16'h0, 0, 0, 3'd7, 16'h0, 16'h0, 16'h0, 0);
    step(0, 0, 16'h0, 0, 0, 3'd7, 16'h0, 16'h0, 16'h0, 0);
    settle();
    chk("rst_busy", 32'(busyvec), 32'h0);
    chk("rst_d1", 32'(d1), 32'h0);

    step(1, 1, 16'h0127, 0, 0, 3'd7, 16'h0, 16'h0, 16'h0, 0);
    settle();
    chk("dec_op", 32'(op), 32'h0);
    chk("dec_lmc", 32'(lmc), 32'h0);
    chk("dec_cc", 32'(cc), 32'h7);
    chk("dec_upper", 32'(upper), 32'h1200);
    chk("dec_signE", 32'(signe), 32'h0012);
    chk("dec_hazard", 32'(hazard), 32'h0);

    step(1, 0, 16'h0, 1, 0, 3'd0, 16'hABCD, 16'h0, 16'h0, 0);
    settle();
    chk("wr_d1", 32'(d1), 32'hABCD);
    step(1, 1, 16'h0017, 0, 0, 3'd7, 16'h0, 16'h0, 16'h0, 0);
    idle();
    settle();
    chk("rd_d2", 32'(d2), 32'hABCD);

    step(1, 1, 16'h001F, 0, 0, 3'd7, 16'h0, 16'h0, 16'h0, 0);
    settle();
    chk("sw_lmc", 32'(lmc), 32'h1);
    chk("sw_cc", 32'(cc), 32'h7);
    step(1, 1, 16'hE017, 0, 0, 3'd7, 16'h0, 16'h0, 16'h0, 0);
    settle();
    chk("sw_opE", 32'(op), 32'hE);
    step(1, 1, 16'hD017, 0, 0, 3'd7, 16'h0, 16'h0, 16'h0, 0);
    settle();
    chk("sw_opD", 32'(op), 32'hD);
    step(1, 1, 16'hF804, 0, 0, 3'd7, 16'h0, 16'h0, 16'h0, 0);
    settle();
    chk("sw_signE", 32'(signe), 32'hFF80);
    step(1, 0, 16'h0, 1, 0, 3'd6, 16'h0, 16'h0, 16'h0, 0);
    settle();
    chk("imm8_wr", 32'(d1), 32'h0080);

    step(1, 1, 16'h0200, 0, 0, 3'd7, 16'h0, 16'h0, 16'h0, 0);
    step(1, 0, 16'h0, 1, 0, 3'd0, 16'h1234, 16'h0, 16'h0, 0);
    settle();
    chk("bypass_d1", 32'(d1), 32'h1234);

    step(1, 1, 16'h0000, 0, 0, 3'd7, 16'h0, 16'h0, 16'h0, 0);
    step(1, 0, 16'h0, 1, 0, 3'd0, 16'hFFFF, 16'h0, 16'h0, 0);
    settle();
    chk("r0_d1", 32'(d1), 32'h0);
    step(1, 0, 16'h0, 1, 1, 3'd2, 16'h0, 16'h0, 16'h0042, 0);
    step(1, 1, 16'h0F00, 0, 0, 3'd7, 16'h0, 16'h0, 16'h0, 0);
    idle();
    settle();
    chk("link_d1", 32'(d1), 32'h0042);

    step(1, 1, 16'h0300, 0, 0, 3'd7, 16'h0, 16'h0, 16'h0, 0);
    step(1, 0, 16'h0, 0, 0, 3'd7, 16'h0, 16'h0, 16'h0, 1);
    settle();
    chk("mark_busy", 32'(busyvec), 32'h0008);
    chk("mark_haz", 32'(hazard), 32'h1);
    step(1, 0, 16'h0, 1, 0, 3'd0, 16'h5555, 16'h0, 16'h0, 0);
    settle();
    chk("clr_busy", 32'(busyvec), 32'h0);
    chk("clr_haz", 32'(hazard), 32'h0);
    step(1, 0, 16'h0, 1, 0, 3'd0, 16'h6666, 16'h0, 16'h0, 1);
    settle();
    chk("setwins", 32'(busyvec), 32'h0008);
    step(0, 0, 16'h0, 1, 0, 3'd0, 16'h7777, 16'h0, 16'h0, 1);
    settle();
    chk("rst_clr", 32'(busyvec), 32'h0);

    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 49) != 0, $urandom_range(0, 2) == 0, 16'($urandom),
           $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, 3'($urandom),
           16'($urandom), 16'($urandom), 16'($urandom), $urandom_range(0, 3) == 0);
    end

    k = 0;
    while (exp_q.size() > 0 && k < 10) begin
      @(posedge clk);
      k++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ir_regfile_pipe.md
Name: ir_regfile_pipe

Overview:
Parametrised successor to the integrated IR/register-file datapath slice of the 16-bit multicycle CPU. It latches the 16-bit instruction from MD and decodes the Op, LMC, CC, upper and signE fields. It holds an NREG x WIDTH register file with a write-back source mux, registered read ports with same-cycle write bypass, and a busy scoreboard that flags read-after-write hazards. It sits between the memory-data register and the ALU operand muxes.

Parameters:
WIDTH, 16, register and data width; must be at least 16.
NREG, 16, number of registers; a power of 2, from 2 to 16; AW = clog2(NREG).
LINK_REG, NREG-1, register index written when WLink=1.
ZERO_R0, 1, when 1, register 0 reads as 0 and writes to it are dropped.
BYPASS, 1, when 1, a same-cycle write forwards into the registered read data.

Ports:
CLK  in  1  rising-edge clock
RST_N  in  1  synchronous active-low reset
IW  in  1  instruction-register write enable
MD  in  16  memory data / instruction word
RW  in  1  register write enable
WLink  in  1  1 = write LINK_REG; 0 = write IR Ra field
RWSrc  in  3  write-back source select
ALUO  in  WIDTH  ALU result
B  in  WIDTH  B operand register
PC  in  WIDTH  program counter
Mark  in  1  set busy bit of current Ra
Op  out  4  IR[15:12]
LMC  out  1  IR[3]
CC  out  3  IR[2:0]
upper  out  WIDTH  IR[11:4] placed in bits [15:8]; all other bits 0
signE  out  WIDTH  IR[11:4] sign-extended to WIDTH
D1  out  WIDTH  read data, address Ra = IR[8+AW-1:8]
D2  out  WIDTH  read data, address Rb = IR[4+AW-1:4]
Hazard  out  1  Ra or Rb busy
BusyVec  out  NREG  scoreboard contents

Behaviour:
- Reset: when RST_N=0 at a rising edge, IR, all registers, D1, D2 and all busy bits go to 0. Reset wins over every other input. Reset mid-write discards the write.
- Decode outputs are combinational from the IR register. They change one cycle after the IW edge.
- IW=1 at an edge: IR <= MD.
- Write-back source by RWSrc:
  - 000 ALUO
  - 001 MD, zero-extended
  - 010 PC
  - 011 B
  - 100 upper
  - 101 signE
  - 110 IR[11:4] zero-extended
  - 111 no write, even when RW=1
- Write address: WA = WLink ? LINK_REG : Ra. Ra and Rb are taken from the current IR, before any same-edge IW update.
- Write: RW=1 and a valid source commits at the edge. A write to register 0 is dropped when ZERO_R0=1.
- Reads: D1/D2 register the array at Ra/Rb every edge, giving 1-cycle latency.
  - BYPASS=1: if the same edge writes address Ra (or Rb), D1 (or D2) takes the written value.
  - BYPASS=0: D1/D2 take the old array value.
  - ZERO_R0=1: a read of register 0 always gives 0.
- Scoreboard:
  - Mark=1 at an edge sets busy[Ra].
  - A committed write to WA clears busy[WA].
  - If the same edge has Mark=1 with Ra==WA, set wins.
  - Register 0 is never busy when ZERO_R0=1.
- Hazard (combinational): busy[Ra] | busy[Rb].
- IW and RW on the same edge: the write uses the old IR fields; the decode outputs update afterwards.
- Address bits above AW in the IR fields are ignored, so addresses wrap modulo NREG.

Decomposition:
- Package ir_rf_pkg holds:
  - RWSrc encodings (RWS_ALUO..RWS_NONE)
  - IR field bit positions (OP_HI/LO, RA_LO, RB_LO, IMM_HI/LO, LMC_BIT, CC_HI/LO)
  - the imm8 width constant
- One sub-module, rf_array: NREG x WIDTH storage with one write port and two registered read ports with optional bypass.
- The IR latch, decode, write-back mux and scoreboard stay in the top module.

Test Plan:
- Reset then decode: drive RST_N=0 for 2 cycles, release, then IW=1 with MD=16'h0127. Expect Op=0, LMC=0, CC=3'b111, upper=16'h1200, signE=16'h0012, D1=D2=0, Hazard=0.
- Write then read: IR=16'h0127, RW=1, RWSrc=000, ALUO=16'hABCD. Register 1 = ABCD; one cycle later D1=16'hABCD. With IR=16'h0017 (Rb=1), D2=16'hABCD.
- Decode sweep: MD=16'h001F gives LMC=1, CC=111. MD=16'hE017 gives Op=E. MD=16'hD017 gives Op=D. MD=16'hF804 gives signE=16'hFF80, and with RWSrc=110 the value written is 16'h0080.
- Bypass: write ALUO=16'h1234 to register 2 while Ra=2. D1=16'h1234 on that same edge with BYPASS=1, and the old value 0 with BYPASS=0.
- R0 and link: RW=1 with Ra=0 and ALUO=16'hFFFF leaves D1=0. With WLink=1, RWSrc=010 and PC=16'h0042, register 15 becomes 0042.
- Scoreboard: Mark=1 with Ra=3 sets BusyVec[3]=1 and Hazard=1. A write to register 3 clears both. A simultaneous Mark and write to register 3 leaves busy=1. RST_N=0 with busy set clears BusyVec to 0.
